frame_flow_ctrl: RTL and testbench
==================================

Name: frame_flow_ctrl

Overview:
- Frame-level sequencer between the upstream AXI-stream pixel source and the line-buffer/convolution/output-FIFO pipeline.
- Opens the input path on a start command and counts input pixels and lines.
- Throttles input on output-FIFO almost-full and counts output beats.
- Drives TLAST on the last output pixel of a frame, emits per-line and frame-done pulses, and supports abort.

Parameters:
- IMG_WIDTH, 512, input pixels per line.
- IMG_HEIGHT, 512, input lines per frame.
- OUT_PIXELS, 261120, output beats per frame: (IMG_HEIGHT-2)*IMG_WIDTH for a 3x3 kernel.
- CNT_W, 20, width of the output beat counter; must satisfy 2^CNT_W > OUT_PIXELS.

Ports:
- axi_clk  in  1  sole clock.
- axi_reset_n  in  1  synchronous active-low reset.
- i_start  in  1  frame start request; sampled only in IDLE.
- i_abort  in  1  abandon the current frame.
- i_data_valid  in  1  upstream pixel valid.
- o_data_ready  out  1  upstream ready.
- i_pipe_full  in  1  output FIFO prog_full.
- o_pixel_valid  out  1  gated valid into the line-buffer controller.
- i_out_valid  in  1  output FIFO m_axis_tvalid (observed).
- i_out_ready  in  1  downstream m_axis_tready (observed).
- o_tlast  out  1  TLAST for the output stream.
- o_line_done  out  1  one-cycle pulse per completed input line.
- o_frame_done  out  1  one-cycle pulse at frame completion.
- o_busy  out  1  high outside IDLE.
- o_overrun  out  1  sticky error flag.
- o_line_idx  out  clog2(IMG_HEIGHT)  current input line.

Behaviour:
- Reset (axi_reset_n=0 at a clock edge):
  - State goes to IDLE; all counters go to 0.
  - All outputs are 0, including o_overrun.
- Input beat: in_beat = i_data_valid & o_data_ready.
- Output beat: out_beat = i_out_valid & i_out_ready.
- o_data_ready = (state==RUN) & ~i_pipe_full. This is combinational with zero latency, so a prog_full assertion blocks the same cycle.
- o_pixel_valid = in_beat (combinational).
- Input counters:
  - x increments on in_beat and wraps IMG_WIDTH-1 -> 0.
  - On the wrap, y increments and o_line_done pulses in the following cycle (registered).
- Output counter: oc increments on out_beat while in RUN or DRAIN.
- o_tlast = (state is RUN or DRAIN) & (oc==OUT_PIXELS-1). It is combinational, so it is valid together with the beat.
- States:
  - IDLE: on i_start go to RUN (1 cycle); clears x, y, oc.
  - RUN: when in_beat occurs at x=IMG_WIDTH-1 and y=IMG_HEIGHT-1, go to DRAIN; input closes the next cycle.
  - DRAIN: o_data_ready=0. When out_beat occurs with oc==OUT_PIXELS-1, go to DONE.
  - DONE: o_frame_done=1 for exactly one cycle, then IDLE; o_busy=0 from that point.
- Early output:
  - Output may finish while still in RUN. The completion condition is input complete AND oc reached OUT_PIXELS.
  - If the final output beat arrives in RUN, a flag is latched and RUN goes directly to DONE on the last input beat.
- Abort:
  - i_abort in RUN, DRAIN or DONE goes to IDLE next cycle and clears counters.
  - No o_frame_done is produced; o_line_done is suppressed.
  - Abort has priority over every other transition.
  - i_abort in IDLE is ignored.
- Simultaneous events:
  - i_start with i_abort in IDLE: start wins.
  - in_beat and out_beat in the same cycle are both counted.
- Overrun: out_beat while in IDLE, or a beat that would push oc beyond OUT_PIXELS, sets o_overrun (sticky until reset). Such beats are not counted.
- i_start is ignored while busy (no queueing).

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=4, OUT_PIXELS=8):
- Reset then idle:
  - Stimulus: hold i_data_valid=1 with no start.
  - Required: o_data_ready=0 and o_pixel_valid=0 throughout.
  - Required: all outputs 0 at reset.
- Full frame:
  - Stimulus: start, 16 continuous valid pixels, output always ready with 8 output beats.
  - Required: 4 o_line_done pulses; o_tlast exactly on the 8th output beat; one o_frame_done; then o_busy=0.
- Backpressure:
  - Stimulus: raise i_pipe_full at input pixel 5 for 3 cycles.
  - Required: o_data_ready=0 in those same 3 cycles; pixel count resumes at 6; the frame still completes with 16 input beats.
- Early output:
  - Stimulus: all 8 output beats arrive before the last input pixel.
  - Required: o_frame_done occurs 1 cycle after the 16th input beat; o_tlast on output beat 8.
- Abort mid-frame:
  - Stimulus: i_abort after 6 input pixels.
  - Required: IDLE next cycle; no o_frame_done; o_line_idx=0.
  - Stimulus (continued): a new start then runs a clean frame.
  - Required: identical behaviour to the full-frame scenario.
- Overrun:
  - Stimulus: an out_beat while in IDLE.
  - Required: o_overrun=1, which stays set across a following full frame until reset.

Source files
------------

// File: rtl/frame_flow_ctrl.sv
// Frame-level sequencer: gates the upstream pixel stream, counts input pixels/lines
// and output beats, and generates TLAST, per-line and frame-done pulses with abort.
module frame_flow_ctrl #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int OUT_PIXELS = 261120,
  parameter int CNT_W      = 20
) (
  input  logic                          axi_clk,
  input  logic                          axi_reset_n,
  input  logic                          i_start,
  input  logic                          i_abort,
  input  logic                          i_data_valid,
  output logic                          o_data_ready,
  input  logic                          i_pipe_full,
  output logic                          o_pixel_valid,
  input  logic                          i_out_valid,
  input  logic                          i_out_ready,
  output logic                          o_tlast,
  output logic                          o_line_done,
  output logic                          o_frame_done,
  output logic                          o_busy,
  output logic                          o_overrun,
  output logic [$clog2(IMG_HEIGHT)-1:0] o_line_idx
);

  localparam int XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int YW = $clog2(IMG_HEIGHT);

  localparam logic [XW-1:0]    X_LAST  = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0]    Y_LAST  = YW'(IMG_HEIGHT - 1);
  localparam logic [CNT_W-1:0] OC_LAST = CNT_W'(OUT_PIXELS - 1);
  localparam logic [CNT_W-1:0] OC_FULL = CNT_W'(OUT_PIXELS);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic [CNT_W-1:0] oc;
  logic             line_done_q;
  logic             overrun_q;
  logic             clear_cnt;

  logic in_beat, out_beat, x_wrap, in_last, out_active, out_last, out_done, out_over;

  assign o_data_ready  = (state == RUN) & ~i_pipe_full;
  assign in_beat       = i_data_valid & o_data_ready;
  assign out_beat      = i_out_valid & i_out_ready;
  assign x_wrap        = in_beat & (x == X_LAST);
  assign in_last       = x_wrap & (y == Y_LAST);
  assign out_active    = (state == RUN) | (state == DRAIN);
  assign out_last      = out_beat & out_active & (oc == OC_LAST);
  // oc parked at OUT_PIXELS doubles as the "output finished early" flag
  assign out_done      = (oc == OC_FULL);
  assign out_over      = out_beat & ((state == IDLE) | (out_active & out_done));

  assign o_pixel_valid = in_beat;
  assign o_tlast       = out_active & (oc == OC_LAST);
  assign o_line_done   = line_done_q;
  assign o_frame_done  = (state == DONE) & ~i_abort;
  assign o_busy        = (state != IDLE);
  assign o_overrun     = overrun_q;
  assign o_line_idx    = y;

  always_comb begin
    state_nxt = state;
    clear_cnt = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_start) begin
          state_nxt = RUN;
          clear_cnt = 1'b1;
        end
      end
      RUN: begin
        if (i_abort) begin
          state_nxt = IDLE;
          clear_cnt = 1'b1;
        end else if (in_last) begin
          // last output beat may land on or before the last input beat
          state_nxt = (out_done | out_last) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (i_abort) begin
          state_nxt = IDLE;
          clear_cnt = 1'b1;
        end else if (out_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        clear_cnt = i_abort;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      oc          <= '0;
      line_done_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state       <= state_nxt;
      overrun_q   <= overrun_q | out_over;
      line_done_q <= x_wrap & ~i_abort;
      if (clear_cnt) begin
        x  <= '0;
        y  <= '0;
        oc <= '0;
      end else begin
        if (in_beat) begin
          x <= x_wrap ? '0 : x + XW'(1);
        end
        if (x_wrap) begin
          y <= (y == Y_LAST) ? '0 : y + YW'(1);
        end
        if (out_beat & out_active & ~out_done) begin
          oc <= oc + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_flow_ctrl.sv
// Directed bench for frame_flow_ctrl on a 4x4 image with 8 output beats per frame.
module tb_frame_flow_ctrl;

  logic       axi_clk;
  logic       axi_reset_n;
  logic       i_start, i_abort, i_data_valid, i_pipe_full, i_out_valid, i_out_ready;
  logic       o_data_ready, o_pixel_valid, o_tlast, o_line_done, o_frame_done, o_busy, o_overrun;
  logic [1:0] o_line_idx;

  int checks   = 0;
  int failures = 0;

  frame_flow_ctrl #(
    .IMG_WIDTH (4),
    .IMG_HEIGHT(4),
    .OUT_PIXELS(8),
    .CNT_W     (4)
  ) dut (
    .axi_clk      (axi_clk),
    .axi_reset_n  (axi_reset_n),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_data_valid (i_data_valid),
    .o_data_ready (o_data_ready),
    .i_pipe_full  (i_pipe_full),
    .o_pixel_valid(o_pixel_valid),
    .i_out_valid  (i_out_valid),
    .i_out_ready  (i_out_ready),
    .o_tlast      (o_tlast),
    .o_line_done  (o_line_done),
    .o_frame_done (o_frame_done),
    .o_busy       (o_busy),
    .o_overrun    (o_overrun),
    .o_line_idx   (o_line_idx)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  typedef struct {
    logic       start, abort, dv, pf, ov, ordy;
    logic       dr, pv, tl, ld, fd, busy, ovr;
    logic [1:0] lidx;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(input logic start, abort, dv, pf, ov, ordy,
                              input logic dr, pv, tl, ld, fd, busy, ovr,
                              input logic [1:0] lidx);
    vec_t v;
    v.start = start; v.abort = abort; v.dv = dv; v.pf = pf; v.ov = ov; v.ordy = ordy;
    v.dr = dr; v.pv = pv; v.tl = tl; v.ld = ld; v.fd = fd; v.busy = busy; v.ovr = ovr;
    v.lidx = lidx;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic start, abort, dv, pf, ov, ordy);
    i_start      = start;
    i_abort      = abort;
    i_data_valid = dv;
    i_pipe_full  = pf;
    i_out_valid  = ov;
    i_out_ready  = ordy;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    axi_reset_n = 1'b0;
    repeat (2) @(posedge axi_clk);
    @(negedge axi_clk);
    #1;
    chk("rst_ready", o_data_ready, 0);
    chk("rst_pixel_valid", o_pixel_valid, 0);
    chk("rst_tlast", o_tlast, 0);
    chk("rst_line_done", o_line_done, 0);
    chk("rst_frame_done", o_frame_done, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_overrun", o_overrun, 0);
    chk("rst_line_idx", o_line_idx, 0);
    axi_reset_n = 1'b1;
  endtask

  task automatic apply_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge axi_clk);
      drive(tbl[i].start, tbl[i].abort, tbl[i].dv, tbl[i].pf, tbl[i].ov, tbl[i].ordy);
      #1;
      chk($sformatf("row%0d_ready", i), o_data_ready, tbl[i].dr);
      chk($sformatf("row%0d_pixel_valid", i), o_pixel_valid, tbl[i].pv);
      chk($sformatf("row%0d_tlast", i), o_tlast, tbl[i].tl);
      chk($sformatf("row%0d_line_done", i), o_line_done, tbl[i].ld);
      chk($sformatf("row%0d_frame_done", i), o_frame_done, tbl[i].fd);
      chk($sformatf("row%0d_busy", i), o_busy, tbl[i].busy);
      chk($sformatf("row%0d_overrun", i), o_overrun, tbl[i].ovr);
      chk($sformatf("row%0d_line_idx", i), o_line_idx, tbl[i].lidx);
      @(posedge axi_clk);
    end
  endtask

  // Continuous-input frame; output beats start once out_start pixels are in.
  // bp_at: pipe_full for 3 cycles after that many pixels (-1 = none).
  // abort_after: abort when that many pixels accepted (-1 = none).
  task automatic run_frame(input int bp_at, input int out_start, input int abort_after,
                           input logic exp_ovr);
    int nin = 0, nout = 0, pf_left = 0, ld_cnt = 0, fd_cnt = 0, idle_cycles;
    logic ld_next = 0, fd_next = 0, complete = 0, finished = 0, aborted = 0;
    logic pf, dv, ab, ov, edr;

    @(negedge axi_clk);
    drive(1, 0, 0, 0, 0, 1);
    #1;
    chk("start_busy", o_busy, 0);
    chk("start_ready", o_data_ready, 0);
    @(posedge axi_clk);

    for (int cyc = 0; cyc < 80 && !finished; cyc++) begin
      @(negedge axi_clk);
      pf  = (pf_left > 0);
      dv  = (nin < 16);
      ab  = (abort_after >= 0) && (nin == abort_after);
      ov  = (nout < 8) && (nin >= out_start);
      edr = dv & ~pf;
      drive(0, ab, dv, pf, ov, 1);
      #1;
      chk("ready", o_data_ready, edr);
      chk("pixel_valid", o_pixel_valid, edr);
      chk("tlast", o_tlast, (nout == 7));
      chk("line_done", o_line_done, ld_next);
      chk("frame_done", o_frame_done, fd_next);
      chk("busy", o_busy, 1);
      chk("line_idx", o_line_idx, (nin / 4) % 4);
      chk("overrun", o_overrun, exp_ovr);
      ld_cnt += int'(o_line_done);
      fd_cnt += int'(o_frame_done);
      @(posedge axi_clk);
      if (ab) begin
        aborted  = 1;
        finished = 1;
      end else if (fd_next) begin
        finished = 1;
      end else begin
        if (edr) nin++;
        ld_next = edr && (nin % 4 == 0);
        if (pf) pf_left--;
        else if (edr && nin == bp_at) pf_left = 3;
        if (ov) nout++;
        fd_next = !complete && nin == 16 && nout == 8;
        if (fd_next) complete = 1;
      end
    end
    if (!finished) chk("frame_timeout", 0, 1);

    idle_cycles = aborted ? 3 : 1;
    for (int k = 0; k < idle_cycles; k++) begin
      @(negedge axi_clk);
      drive(0, 0, 0, 0, 0, 0);
      #1;
      chk("post_busy", o_busy, 0);
      chk("post_frame_done", o_frame_done, 0);
      chk("post_line_done", o_line_done, 0);
      chk("post_ready", o_data_ready, 0);
      chk("post_line_idx", o_line_idx, 0);
      fd_cnt += int'(o_frame_done);
      @(posedge axi_clk);
    end

    if (aborted) begin
      chk("abort_frame_done_count", fd_cnt, 0);
    end else begin
      chk("line_done_count", ld_cnt, 4);
      chk("frame_done_count", fd_cnt, 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //             st ab dv pf ov or   dr pv tl ld fd by ov lidx
    tbl[0]  = mk(0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 1, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 1, 0, 0);
    tbl[5]  = mk(0, 0, 1, 1, 0, 0,   0, 0, 0, 0, 0, 1, 0, 0);
    tbl[6]  = mk(0, 1, 1, 0, 0, 0,   1, 1, 0, 0, 0, 1, 0, 0);
    tbl[7]  = mk(0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 0, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 0);
    tbl[10] = mk(0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 0);

    axi_reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    do_reset();

    apply_rows(0, 7);                // idle, ignored abort, start-vs-abort, same-cycle backpressure
    run_frame(-1, 12, -1, 1'b0);     // full frame, tail of output drains after input
    run_frame(5, 12, -1, 1'b0);      // backpressure after pixel 5
    run_frame(-1, 4, -1, 1'b0);      // all output beats before the last input pixel
    run_frame(-1, 12, 6, 1'b0);      // abort after 6 pixels
    run_frame(-1, 12, -1, 1'b0);     // clean frame after abort
    apply_rows(8, 10);               // output beat while idle
    run_frame(-1, 12, -1, 1'b1);     // overrun stays set through a frame
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
